// File: rtl/instr_fetch_responder.sv
// Instruction-memory responder for the CPU fetch interface. It has a word-addressed
// program store that a separate loader port writes. A fetch returns
// mem[pc[ADDR_WIDTH+1:2]] LATENCY edges after the request is accepted.
// Ports:
//   clk, reset                     - clock and synchronous active-high reset
//   pc, req / ready                - fetch request (byte address); accepted when req && ready
//   instruction, valid             - registered response word and its one-cycle valid pulse
//   misaligned, out_of_range       - registered request flags, updated with instruction
//   load_en, load_addr, load_data  - program-store write port, active in any state
module instr_fetch_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  input  logic                  req,
  output logic                  ready,
  output logic [31:0]           instruction,
  output logic                  valid,
  output logic                  misaligned,
  output logic                  out_of_range,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  mis_q;
  logic                  oor_q;
  logic [31:0]           rd_data;
  logic                  accept;
  logic                  read_edge;

  logic [31:0] mem [DEPTH];

  assign accept    = req && ready;
  assign read_edge = (state == WAIT) && (cnt == 4'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = req ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state. They come straight from a register, so there is no
  // combinational path from any input.
  always_comb begin
    ready = 1'b0;
    valid = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      RESP:    begin ready = 1'b1; valid = 1'b1; end
      default: begin ready = 1'b0; valid = 1'b0; end
    endcase
  end

  // Read mux. A load to the word being read on the read edge is forwarded, so the
  // response reflects that write (write-first).
  always_comb begin
    rd_data = mem[idx];
    if (oor_q) begin
      rd_data = RESET_INSTR;
    end else if (load_en && (load_addr == idx)) begin
      rd_data = load_data;
    end
  end

  // Request capture, latency counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= 4'd0;
      idx          <= '0;
      mis_q        <= 1'b0;
      oor_q        <= 1'b0;
      instruction  <= RESET_INSTR;
      misaligned   <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      if (accept) begin
        idx   <= pc[ADDR_WIDTH+1:2];
        mis_q <= (pc[1:0] != 2'b00);
        oor_q <= (pc[31:ADDR_WIDTH+2] != '0);
        cnt   <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (read_edge) begin
        instruction  <= rd_data;
        misaligned   <= mis_q;
        out_of_range <= oor_q;
      end
    end
  end

  // Program store. It has no reset, and a load is still taken on a reset edge.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Testbench for instr_fetch_responder (LATENCY=2). Directed scenarios run first,
// followed by randomized traffic. Every cycle is compared against a transaction-level
// reference model.
module tb_instr_fetch_responder;

  localparam int          AW  = 10;
  localparam int          LAT = 2;
  localparam logic [31:0] RST = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc;
  logic          req;
  logic          ready;
  logic [31:0]   instruction;
  logic          valid;
  logic          misaligned;
  logic          out_of_range;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;

  instr_fetch_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .RESET_INSTR(RST)) dut (
    .clk(clk), .reset(reset), .pc(pc), .req(req), .ready(ready),
    .instruction(instruction), .valid(valid), .misaligned(misaligned),
    .out_of_range(out_of_range), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model. It tracks the outstanding fetch by the edge number on which its
  // read is due, and keeps a copy of the program store.
  logic [31:0]   mm [1 << AW];
  int            e = 0;
  bit            pend = 0;
  int            rd_edge = 0;
  logic [AW-1:0] m_idx = '0;
  bit            m_mis = 0, m_oor = 0;
  bit            m_vld = 0;
  logic [31:0]   m_instr = RST;
  bit            m_mo = 0, m_oo = 0;
  bit            acc = 0;

  task automatic model_edge();
    acc = 0;
    if (reset) begin
      pend = 0; m_vld = 0; m_instr = RST; m_mo = 0; m_oo = 0;
    end else begin
      m_vld = 0;
      if (pend && e == rd_edge) begin
        if (m_oor) m_instr = RST;
        else if (load_en && load_addr == m_idx) m_instr = load_data;
        else m_instr = mm[m_idx];
        m_mo = m_mis; m_oo = m_oor; m_vld = 1; pend = 0;
      end else if (!pend && req) begin
        acc = 1; pend = 1; rd_edge = e + LAT;
        m_idx = pc[AW+1:2];
        m_mis = (pc[1:0] != 2'b00);
        m_oor = (pc[31:AW+2] != '0);
      end
    end
    if (load_en) mm[load_addr] = load_data;
    e++;
  endtask

  // One clock: update the model at the edge, then compare every output at the
  // following falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ready", {31'b0, ready}, {31'b0, !pend});
    chk("valid", {31'b0, valid}, {31'b0, m_vld});
    chk("instruction", instruction, m_instr);
    chk("misaligned", {31'b0, misaligned}, {31'b0, m_mo});
    chk("out_of_range", {31'b0, out_of_range}, {31'b0, m_oo});
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    load_en = 1; load_addr = a; load_data = d;
    cycle();
    load_en = 0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid && n < 40) begin cycle(); n++; end
    chk({tag, "_timeout"}, {31'b0, valid}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] a, input string tag);
    int n = 0;
    req = 1; pc = a;
    do begin cycle(); n++; end while (!acc && n < 40);
    req = 0;
    wait_valid(tag);
  endtask

  initial begin
    logic [31:0] got_q[$];
    int          at_q[$];
    int          naccept;
    int          cyc;

    reset = 1; req = 0; pc = '0; load_en = 0; load_addr = '0; load_data = '0;
    cycle(); cycle();
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_instr", instruction, RST);
    reset = 0;

    // Preload the whole store so that every later read is defined
    for (int i = 0; i < (1 << AW); i++) load(AW'(i), $urandom);

    // Basic fetch
    load(10'd203, 32'h0800_0000 | 32'd203);
    req = 1; pc = 32'h32C;
    cycle();
    req = 0;
    chk("bf_ready_w0", {31'b0, ready}, 32'd0);
    cycle();
    chk("bf_ready_w1", {31'b0, ready}, 32'd0);
    cycle();
    chk("bf_valid", {31'b0, valid}, 32'd1);
    chk("bf_instr", instruction, 32'h0800_00CB);
    chk("bf_mis", {31'b0, misaligned}, 32'd0);
    chk("bf_oor", {31'b0, out_of_range}, 32'd0);
    cycle();
    chk("bf_valid_end", {31'b0, valid}, 32'd0);

    // Back-to-back: hold req and step pc after each accept
    load(10'd0, 32'd1); load(10'd1, 32'd2); load(10'd2, 32'd3);
    req = 1; pc = 32'd0; naccept = 0; cyc = 0;
    while (got_q.size() < 3 && cyc < 60) begin
      cycle(); cyc++;
      if (acc) begin
        naccept++; pc = pc + 32'd4;
        if (naccept == 3) req = 0;
      end
      if (valid) begin got_q.push_back(instruction); at_q.push_back(cyc); end
    end
    req = 0;
    chk("b2b_count", got_q.size(), 32'd3);
    for (int i = 0; i < got_q.size(); i++) chk("b2b_data", got_q[i], 32'(i + 1));
    for (int i = 1; i < at_q.size(); i++) chk("b2b_gap", 32'(at_q[i] - at_q[i-1]), 32'(LAT + 1));
    cycle();

    // Flags
    fetch(32'h0000_032E, "mis");
    chk("mis_flag", {31'b0, misaligned}, 32'd1);
    chk("mis_instr", instruction, 32'h0800_00CB);
    fetch(32'h0000_1000, "oor");
    chk("oor_flag", {31'b0, out_of_range}, 32'd1);
    chk("oor_instr", instruction, 32'h0);
    cycle();

    // A load on the read edge is forwarded into the response
    load(10'd5, 32'hAAAA_0000);
    req = 1; pc = 32'd20;
    cycle();
    req = 0;
    for (int i = 0; i < LAT - 1; i++) cycle();
    load(10'd5, 32'h5555_FFFF);
    chk("wf_valid", {31'b0, valid}, 32'd1);
    chk("wf_instr", instruction, 32'h5555_FFFF);
    load(10'd5, 32'hAAAA_0000);
    req = 1; pc = 32'd20;
    cycle();
    req = 0;
    for (int i = 0; i < LAT; i++) cycle();
    chk("wl_instr", instruction, 32'hAAAA_0000);
    load(10'd5, 32'h5555_FFFF);
    chk("wl_hold", instruction, 32'hAAAA_0000);

    // Reset mid-fetch
    req = 1; pc = 32'h32C;
    cycle();
    req = 0; reset = 1;
    cycle();
    reset = 0;
    chk("rm_ready", {31'b0, ready}, 32'd1);
    chk("rm_valid", {31'b0, valid}, 32'd0);
    chk("rm_instr", instruction, RST);
    for (int i = 0; i < LAT + 2; i++) begin
      cycle();
      chk("rm_novalid", {31'b0, valid}, 32'd0);
    end
    fetch(32'h32C, "rm_refetch");
    chk("rm_refetch_instr", instruction, 32'h0800_00CB);
    cycle();

    // A request raised during WAIT is dropped
    req = 1; pc = 32'h32C;
    cycle();
    pc = 32'd20;
    cycle();
    req = 0;
    wait_valid("drop");
    chk("drop_instr", instruction, 32'h0800_00CB);
    for (int i = 0; i < LAT + 2; i++) begin
      cycle();
      chk("drop_novalid", {31'b0, valid}, 32'd0);
    end

    // Randomized traffic, including resets, loads aimed at the pending word, and
    // pc changes while a fetch is outstanding
    for (int i = 0; i < 3000; i++) begin
      int r;
      reset = ($urandom_range(99) == 0);
      req   = ($urandom_range(2) != 0);
      r     = $urandom_range(9);
      if (r <= 5)      pc = {20'b0, 10'($urandom), 2'b00};
      else if (r <= 7) pc = {20'b0, 10'($urandom), 2'($urandom_range(3, 1))};
      else if (r == 8) pc = {20'($urandom_range(32'hFFFFF, 1)), 12'($urandom)};
      else             pc = $urandom;
      load_en   = ($urandom_range(3) == 0);
      load_addr = ($urandom_range(1) == 0) ? m_idx : 10'($urandom);
      load_data = $urandom;
      cycle();
    end
    reset = 0; req = 0; load_en = 0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
